// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer and its neighbours.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_MAX     = 16;

endpackage

// File: rtl/btn_debounce_edge_if.sv
// Button-side bundle: raw level in, debounced level, edge strobes and busy out.
interface btn_debounce_edge_if;

    logic btn_in;
    logic db_out;
    logic rise;
    logic fall;
    logic busy;

    modport master (output btn_in, input db_out, input rise, input fall, input busy);
    modport slave  (input btn_in, output db_out, output rise, output fall, output busy);

endinterface

// File: rtl/sync_chain.sv
// N-flop metastability synchronizer with asynchronous active-low clear.
module sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (N < 2) begin : gen_bad_n
        $error("sync_chain: N must be >= 2");
    end

    logic [N-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[N-2:0], d};
        end
    end

    assign q = chain_q[N-1];

endmodule

// File: rtl/btn_debounce_edge.sv
// Debounces a raw button into a registered level plus single-cycle rise/fall strobes.
module btn_debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_MAX     = DEF_CNT_MAX
) (
    input logic                clk,
    input logic                rst_n,
    btn_debounce_edge_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    if (SYNC_STAGES < 2) begin : gen_bad_sync
        $error("btn_debounce_edge: SYNC_STAGES must be >= 2");
    end
    if (CNT_MAX < 2) begin : gen_bad_cnt
        $error("btn_debounce_edge: CNT_MAX must be >= 2");
    end

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STABLE_LOW:  if (s) state_d = WAIT_HIGH;
            WAIT_HIGH: begin
                if (!s)                    state_d = STABLE_LOW;
                else if (cnt_q == CNT_LAST) state_d = STABLE_HIGH;
            end
            STABLE_HIGH: if (!s) state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (s)                     state_d = STABLE_HIGH;
                else if (cnt_q == CNT_LAST) state_d = STABLE_LOW;
            end
            default:     state_d = STABLE_LOW;
        endcase
    end

    // Any opposite sample while waiting leaves cnt_d at zero, restarting qualification.
    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (s) begin
                    if (cnt_q == CNT_LAST) begin
                        db_d   = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (!s) begin
                    if (cnt_q == CNT_LAST) begin
                        db_d   = 1'b0;
                        fall_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.db_out = db_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench for btn_debounce_edge at default parameters (latency 18 edges).
module tb_btn_debounce_edge;

    logic clk = 1'b0;
    logic rst_n;

    btn_debounce_edge_if bus ();

    btn_debounce_edge #(
        .SYNC_STAGES (2),
        .CNT_MAX     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean level change captured at edge 0; commit expected after edge 18.
    task automatic transition(input string name, input logic lvl, input int last_e);
        int pulses;
        pulses = 0;
        bus.btn_in = lvl;
        for (int e = 0; e <= last_e; e++) begin
            tick();
            check($sformatf("%s e%0d db_out", name, e), 32'(bus.db_out),
                  32'((e >= 18) ? lvl : !lvl));
            check($sformatf("%s e%0d rise", name, e), 32'(bus.rise), 32'(lvl && (e == 18)));
            check($sformatf("%s e%0d fall", name, e), 32'(bus.fall), 32'(!lvl && (e == 18)));
            check($sformatf("%s e%0d busy", name, e), 32'(bus.busy), 32'((e >= 2) && (e <= 17)));
            if (bus.rise || bus.fall) pulses++;
        end
        check($sformatf("%s pulse count", name), 32'(pulses), (last_e >= 18) ? 32'd1 : 32'd0);
    endtask

    initial begin
        bus.btn_in = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("async reset outputs", 32'({bus.db_out, bus.rise, bus.fall, bus.busy}), 32'h0);
        repeat (3) tick();
        #3 rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("idle c%0d", i), 32'({bus.db_out, bus.rise, bus.fall, bus.busy}),
                  32'h0);
        end

        transition("press", 1'b1, 20);
        transition("release", 1'b0, 20);

        // High for 10 edges, low at edge 10, high again from edge 11 (new edge 0 = 11).
        for (int e = 0; e <= 31; e++) begin
            bus.btn_in = (e != 10);
            tick();
            check($sformatf("bounce e%0d rise", e), 32'(bus.rise), 32'(e == 29));
            check($sformatf("bounce e%0d db_out", e), 32'(bus.db_out), 32'(e >= 29));
            check($sformatf("bounce e%0d busy", e), 32'(bus.busy),
                  32'(((e >= 2) && (e <= 11)) || ((e >= 13) && (e <= 28))));
        end

        transition("release2", 1'b0, 20);

        // Single-cycle glitch: WAIT_HIGH for exactly one cycle, no commit.
        for (int e = 0; e <= 25; e++) begin
            bus.btn_in = (e == 0);
            tick();
            check($sformatf("glitch e%0d db/rise", e), 32'({bus.db_out, bus.rise}), 32'h0);
            check($sformatf("glitch e%0d busy", e), 32'(bus.busy), 32'(e == 2));
        end

        // Reach cnt=9 in WAIT_HIGH, then reset between clock edges.
        bus.btn_in = 1'b1;
        repeat (12) tick();
        check("midwait busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midwait reset outputs", 32'({bus.db_out, bus.rise, bus.fall, bus.busy}), 32'h0);
        #2 rst_n = 1'b1;
        transition("post_reset", 1'b1, 20);

        // Reset while a fall strobe is high must drop it without a clock edge.
        transition("fall_flight", 1'b0, 18);
        #2 rst_n = 1'b0;
        #1;
        check("flight reset outputs", 32'({bus.db_out, bus.rise, bus.fall, bus.busy}), 32'h0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("after c%0d", i), 32'({bus.db_out, bus.rise, bus.fall, bus.busy}),
                  32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debounce_edge.md
Name: btn_debounce_edge

Overview:
- Conditions a raw, asynchronous, bouncing push-button or switch input into a clean level and single-cycle edge pulses.
- Sits directly upstream of the D flip-flop and register stages; `db_out` drives their D input.
- Internals: a multi-stage synchronizer, a stability counter and a 4-state FSM.
- Provides registered rise and fall strobes for counters and toggles further downstream.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops. Must be >= 2; elaboration error otherwise.
- CNT_MAX, 16, number of consecutive stable cycles required to commit a level change. Must be >= 2; elaboration error otherwise.
- CNT_W, $clog2(CNT_MAX), counter width. Derived; not overridden by users.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous assert, active-low.
- btn_in  input  1  raw asynchronous button/switch level.
- db_out  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when db_out goes 0->1, registered.
- fall  output  1  one-cycle pulse when db_out goes 1->0, registered.
- busy  output  1  high while a candidate change is being qualified (WAIT states).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Every flop clears immediately on rst_n=0, independent of clk.
- Reset values:
  - sync chain all 0
  - state STABLE_LOW
  - cnt 0
  - db_out 0, rise 0, fall 0, busy 0
- Synchronizer: btn_in shifts through SYNC_STAGES flops; the FSM only sees the last stage, `s`.
- FSM states and transitions, evaluated on each rising clk:
  - STABLE_LOW: if s=1, go to WAIT_HIGH with cnt<=0; else stay.
  - WAIT_HIGH:
    - if s=0, go to STABLE_LOW with cnt<=0 (bounce rejected; no pulse).
    - else if cnt==CNT_MAX-1, go to STABLE_HIGH with db_out<=1, rise<=1, cnt<=0.
    - else cnt<=cnt+1.
  - STABLE_HIGH: if s=0, go to WAIT_LOW with cnt<=0; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH. s=1 returns to STABLE_HIGH; commit sets db_out<=0, fall<=1.
- rise and fall are high for exactly one cycle. They are never high together.
- busy = (state==WAIT_HIGH || state==WAIT_LOW). Decoded from registered state; no input path.
- Latency:
  - Let edge 0 be the first clk edge at which stage 1 captures the new btn_in level, with btn_in stable from then on.
  - db_out and the pulse change after edge SYNC_STAGES+CNT_MAX. Default: edge 18.
- Counter: counts 0..CNT_MAX-1 and never wraps. A reset to 0 on bounce is mandatory; a bounce never decrements or holds the count.
- Bounce: any opposite sample in a WAIT state restarts qualification from zero. The next qualifying run needs the full CNT_MAX again.
- Pulses narrower than SYNC_STAGES+1 cycles are not guaranteed to reach `s`; those that do still need CNT_MAX stability.
- Reset mid-operation:
  - rst_n low in any state aborts qualification. Outputs drop to reset values in the same instant, including a rise/fall pulse in flight.
  - After release with btn_in held high, the input is treated as a fresh press: full latency, then rise=1.
- Reset release: synchronous deassertion of rst_n is the integrator's responsibility; this block contains no reset synchronizer.

Decomposition:
- Package debounce_pkg:
  - state typedef, 2-bit: STABLE_LOW=2'b00, WAIT_HIGH=2'b01, STABLE_HIGH=2'b11, WAIT_LOW=2'b10.
  - default constants DEF_SYNC_STAGES=2 and DEF_CNT_MAX=16.
- Sub-module sync_chain:
  - parameter N.
  - ports clk, rst_n, d, q.
  - async active-low reset to 0.
  - reusable by other input-conditioning blocks.

Test Plan:
- Reset with btn_in=0, hold 30 cycles -> db_out=0, rise=fall=busy=0 throughout.
- btn_in 0->1 clean at edge 0 (defaults) -> busy high from edge 2 to edge 18; db_out=1 and rise=1 after edge 18; rise=0 after edge 19; exactly one rise pulse.
- Bounce: btn_in=1 for 10 cycles, 0 for 1 cycle, then 1 -> no rise after the first run; busy drops; rise occurs 18 edges after the final 0->1, counted per the latency definition.
- Release from STABLE_HIGH: btn_in 1->0 clean -> fall=1 for one cycle after edge 18; db_out=0; no rise in the same cycle.
- Glitch: 1-cycle btn_in=1 pulse -> db_out stays 0 and rise never asserts; busy may pulse for at most 2 cycles.
- rst_n=0 asserted mid-WAIT_HIGH (cnt=9) with btn_in held 1 -> outputs 0 immediately without a clk edge; after release, rise after edge 18 relative to release.
